// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding.
package serial_adder_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder built from two half-adder stages plus a carry OR.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g;

    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign co = g | (p & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: runs one full-adder cell over WIDTH cycles, LSB first,
// and presents a registered sum/carry with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c_q;
    logic             s_bit;
    logic             c_nxt;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c_q),
        .s  (s_bit),
        .co (c_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c_q   <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c_q   <= cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= {s_bit, s_sh[WIDTH-1:1]};
                    c_q  <= c_nxt;
                    // Hold the counter on the final edge so it never wraps.
                    if (cnt == LAST_BIT) begin
                        sum   <= {s_bit, s_sh[WIDTH-1:1]};
                        cout  <= c_nxt;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: directed table and corner sequences on a WIDTH=8 instance,
// randomized operations against an arithmetic reference on a WIDTH=4 instance.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until done8 is seen, bounded; returns edges waited.
    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        a8     = ia;
        b8     = ib;
        cin8   = ic;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    initial begin
        int         n;
        logic [4:0] exp5;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[5] = '{8'h3C, 8'h0B, 1'b1, 8'h48, 1'b0};

        // Reset state
        #12;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_sum4", 32'(sum4), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven single operations
        for (int i = 0; i < 6; i++) begin
            issue8(vecs[i].a, vecs[i].b, vecs[i].cin);
            check("vec_busy_after_start", 32'(busy8), 32'd1);
            wait_done8(n);
            check("vec_latency", 32'(n), 32'd8);
            check("vec_sum", 32'(sum8), 32'(vecs[i].sum));
            check("vec_cout", 32'(cout8), 32'(vecs[i].cout));
            tick();
            check("vec_done_pulse", 32'(done8), 32'd0);
            check("vec_idle_busy", 32'(busy8), 32'd0);
            check("vec_sum_held", 32'(sum8), 32'(vecs[i].sum));
        end

        // Start held during RUN with changed operands: ignored, then back-to-back
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h55;
        wait_done8(n);
        check("hold_latency", 32'(n), 32'd8);
        check("hold_sum", 32'(sum8), 32'h02);
        check("hold_cout", 32'(cout8), 32'd0);
        tick();
        start8 = 1'b0;
        check("hold_b2b_busy", 32'(busy8), 32'd1);
        check("hold_b2b_done", 32'(done8), 32'd0);
        wait_done8(n);
        check("hold_b2b_latency", 32'(n), 32'd8);
        check("hold_b2b_sum", 32'(sum8), 32'h56);
        tick();

        // Reset during the 4th RUN cycle
        issue8(8'h11, 8'h22, 1'b0);
        tick(); tick(); tick();
        check("midrun_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8 || busy8) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);
        issue8(8'h03, 8'h04, 1'b0);
        wait_done8(n);
        check("post_abort_latency", 32'(n), 32'd8);
        check("post_abort_sum", 32'(sum8), 32'h07);
        check("post_abort_cout", 32'(cout8), 32'd0);
        tick();

        // Back-to-back from DONE with no idle cycle
        issue8(8'h10, 8'h20, 1'b0);
        wait_done8(n);
        check("b2b_first_sum", 32'(sum8), 32'h30);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("b2b_no_bubble", 32'(busy8), 32'd1);
        check("b2b_sum_stable", 32'(sum8), 32'h30);
        wait_done8(n);
        check("b2b_latency", 32'(n), 32'd8);
        check("b2b_sum", 32'(sum8), 32'h00);
        check("b2b_cout", 32'(cout8), 32'd1);
        tick();

        // Randomized WIDTH=4 operations against plain arithmetic
        for (int op = 0; op < 200; op++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            int         lat;
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            exp5 = 5'(ra) + 5'(rb) + 5'(rc);
            a4 = ra; b4 = rb; cin4 = rc; start4 = 1'b1;
            tick();
            lat = 0;
            // Scramble inputs and poke start while busy; none of it may matter.
            for (int k = 0; k < 3; k++) begin
                a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
                start4 = 1'($urandom);
                if (busy4 && !done4) lat++;
                tick();
            end
            start4 = 1'b0;
            if (busy4 && !done4) lat++;
            tick();
            check("rnd_busy_cycles", 32'(lat), 32'd4);
            check("rnd_done_at_w_plus_1", 32'(done4), 32'd1);
            check("rnd_result", {27'd0, cout4, sum4}, {27'd0, exp5});
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
